// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared constants and types for the MAC backoff timer
//
// Purpose: slot timing, backoff exponent cap and attempt limit constants for a
// half-duplex MII MAC, plus the backoff timer state encoding.
// Ports: none (package).

package mac_pkg;

   localparam int SLOT_CYCLES_MII = 128;  // 512 bit times at 4 bits/clk
   localparam int BACKOFF_LIMIT   = 10;
   localparam int ATTEMPT_LIMIT   = 16;

   typedef enum logic {
      IDLE,
      WAIT
   } backoff_state_t;

   // Backoff exponent: the collision number, truncated at the cap.
   function automatic int backoff_exp(input int n, input int limit);
      return (n > limit) ? limit : n;
   endfunction

endpackage

// File: rtl/mac_backoff.sv
// rtl/mac_backoff.sv - truncated binary exponential backoff timer
//
// Purpose: on each collision, draws a random slot count from the upstream LFSR
// word, masked to k = min(attempt, BACKOFF_LIMIT) bits, and waits that many
// slot times before pulsing done. The ATTEMPT_LIMIT-th collision pulses abort.
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   rng_in    free-running random word, sampled only on the collision cycle
//   collision single-cycle pulse, transmit attempt collided
//   success   single-cycle pulse, frame sent, clears the attempt count
//   busy      high while a backoff wait is in progress
//   done      single-cycle pulse, backoff expired, retry permitted
//   abort     single-cycle pulse, attempt limit reached, drop the frame
//   attempt   collision count for the current frame

module mac_backoff #(
   parameter int RNG_WIDTH     = 16,
   parameter int SLOT_CYCLES   = mac_pkg::SLOT_CYCLES_MII,
   parameter int BACKOFF_LIMIT = mac_pkg::BACKOFF_LIMIT,
   parameter int ATTEMPT_LIMIT = mac_pkg::ATTEMPT_LIMIT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [RNG_WIDTH-1:0] rng_in,
   input  logic                 collision,
   input  logic                 success,
   output logic                 busy,
   output logic                 done,
   output logic                 abort,
   output logic [4:0]           attempt
);

   import mac_pkg::*;

   localparam int SW = BACKOFF_LIMIT;
   localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
   localparam logic [CW-1:0] CYC_RELOAD = CW'(SLOT_CYCLES - 1);

   backoff_state_t  state;
   logic [SW-1:0]   slot_cnt;
   logic [CW-1:0]   cyc_cnt;

   logic [4:0]      n_next;
   logic            limit_hit;
   logic [SW-1:0]   slots;

   // A success in the same cycle as a collision restarts the count, so the
   // collision is treated as the first attempt of a new frame.
   always_comb begin
      n_next    = success ? 5'd1 : attempt + 5'd1;
      limit_hit = (n_next == 5'(ATTEMPT_LIMIT));
      slots     = '0;
      for (int i = 0; i < SW; i++) begin
         if (i < backoff_exp(int'(n_next), BACKOFF_LIMIT)) begin
            slots[i] = rng_in[i];
         end
      end
   end

   // Bits above the exponent cap never contribute to the slot count.
   generate
      if (RNG_WIDTH > SW) begin : g_rng_upper
         logic unused_rng_upper;
         assign unused_rng_upper = ^rng_in[RNG_WIDTH-1:SW];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         abort    <= 1'b0;
         attempt  <= 5'd0;
         slot_cnt <= '0;
         cyc_cnt  <= '0;
      end else begin
         done  <= 1'b0;
         abort <= 1'b0;
         if (success) begin
            attempt <= 5'd0;
         end
         case (state)
            IDLE: begin
               if (collision) begin
                  if (limit_hit) begin
                     abort   <= 1'b1;
                     attempt <= 5'd0;
                  end else begin
                     attempt <= n_next;
                     if (slots == '0) begin
                        done <= 1'b1;
                     end else begin
                        state    <= WAIT;
                        busy     <= 1'b1;
                        slot_cnt <= slots;
                        cyc_cnt  <= CYC_RELOAD;
                     end
                  end
               end
            end
            WAIT: begin
               // Collisions are ignored here; only the counters advance.
               if (cyc_cnt == '0) begin
                  if (slot_cnt == SW'(1)) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     slot_cnt <= slot_cnt - SW'(1);
                     cyc_cnt  <= CYC_RELOAD;
                  end
               end else begin
                  cyc_cnt <= cyc_cnt - CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_backoff.sv
// tb/tb_mac_backoff.sv - scoreboard bench for the MAC backoff timer

module tb_mac_backoff;

   localparam int SLOT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] rng_in;
   logic        collision;
   logic        success;
   logic        busy;
   logic        done;
   logic        abort;
   logic [4:0]  attempt;

   always #5 clk = ~clk;

   mac_backoff #(
      .RNG_WIDTH(16),
      .SLOT_CYCLES(SLOT),
      .BACKOFF_LIMIT(10),
      .ATTEMPT_LIMIT(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .rng_in(rng_in),
      .collision(collision),
      .success(success),
      .busy(busy),
      .done(done),
      .abort(abort),
      .attempt(attempt)
   );

   typedef struct {
      bit is_abort;
      int cycle;
      int att;
   } exp_t;

   exp_t sbq[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fails = 0;
   int   m_attempt = 0;
   int   bs = 0;
   int   be = 0;
   int   last_evt = 0;
   bit   mon_on = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: collision number, capped exponent, masked slot count,
   // wait = slots * slot time, computed with plain arithmetic.
   task automatic collide(input logic [15:0] r, input bit s);
      int n, k, slots, e0;
      e0        = cyc + 1;
      n         = s ? 1 : m_attempt + 1;
      rng_in    = r;
      collision = 1'b1;
      success   = s;
      if (n == 16) begin
         sbq.push_back('{1'b1, e0, 0});
         m_attempt = 0;
         last_evt  = e0;
      end else begin
         k         = (n > 10) ? 10 : n;
         slots     = int'(r) % (1 << k);
         m_attempt = n;
         last_evt  = e0 + slots * SLOT;
         sbq.push_back('{1'b0, last_evt, n});
         bs = e0;
         be = e0 + slots * SLOT;
      end
      tick();
      collision = 1'b0;
      success   = 1'b0;
      rng_in    = 16'($urandom);
   endtask

   task automatic wait_idle();
      while (cyc <= last_evt) tick();
      check("pending responses", sbq.size(), 0);
      sbq.delete();
   endtask

   task automatic clear_attempt();
      success = 1'b1;
      tick();
      success   = 1'b0;
      m_attempt = 0;
      tick();
      check("attempt after success", int'(attempt), 0);
   endtask

   // Monitor: busy against the model window every cycle; each done/abort
   // pops one expected response.
   always @(negedge clk) begin
      exp_t e;
      if (mon_on && !rst) begin
         check("busy", int'(busy), int'(cyc >= bs && cyc < be));
         check("done and abort together", int'(done & abort), 0);
         if (done || abort) begin
            if (sbq.size() == 0) begin
               n_checks++;
               n_fails++;
               $display("FAIL spurious output: done=%0d abort=%0d at cycle %0d, expected none",
                        done, abort, cyc);
            end else begin
               e = sbq.pop_front();
               check("abort vs done", int'(abort), int'(e.is_abort));
               check("event cycle", cyc, e.cycle);
               check("attempt at event", int'(attempt), e.att);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [15:0] r;
      bit          s;
      rst       = 1'b1;
      collision = 1'b0;
      success   = 1'b0;
      rng_in    = 16'h0000;
      repeat (3) tick();
      check("reset busy", int'(busy), 0);
      check("reset done", int'(done), 0);
      check("reset abort", int'(abort), 0);
      check("reset attempt", int'(attempt), 0);
      rst    = 1'b0;
      mon_on = 1'b1;

      // k=1, slots=1: busy for one slot, then done
      collide(16'hFFFF, 1'b0);
      wait_idle();
      check("attempt base", int'(attempt), 1);

      // collision during WAIT is ignored
      collide(16'h0003, 1'b0);
      repeat (4) tick();
      collision = 1'b1;
      rng_in    = 16'hFFFF;
      tick();
      collision = 1'b0;
      wait_idle();
      check("attempt after ignored collision", int'(attempt), 2);

      // two immediate expiries then 3-bit mask, slots=5
      clear_attempt();
      collide(16'h0000, 1'b0);
      collide(16'h0000, 1'b0);
      collide(16'h0005, 1'b0);
      wait_idle();
      check("attempt third", int'(attempt), 3);

      // exponent capped at 10: slots=1023
      clear_attempt();
      repeat (11) collide(16'h0000, 1'b0);
      collide(16'hFFFF, 1'b0);
      wait_idle();
      check("attempt capped", int'(attempt), 12);

      // 16th collision aborts
      clear_attempt();
      repeat (15) collide(16'h0000, 1'b0);
      collide(16'($urandom), 1'b0);
      wait_idle();
      check("attempt after abort", int'(attempt), 0);

      // reset mid-wait cancels everything
      clear_attempt();
      collide(16'h0000, 1'b0);
      collide(16'h0000, 1'b0);
      collide(16'h0005, 1'b0);
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sbq.delete();
      m_attempt = 0;
      bs        = 0;
      be        = 0;
      check("busy after reset", int'(busy), 0);
      check("attempt after reset", int'(attempt), 0);
      last_evt = cyc + 30;
      wait_idle();

      // success with collision at attempt 5: first attempt, 1-bit mask
      repeat (5) collide(16'h0000, 1'b0);
      collide(16'hFFFF, 1'b1);
      wait_idle();
      check("attempt success+collision", int'(attempt), 1);

      // randomized collisions and success pulses
      for (int i = 0; i < 60; i++) begin
         r = 16'($urandom_range(0, 63)) | (16'($urandom) & 16'hFC00);
         s = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 5) == 0) begin
            success = 1'b1;
            tick();
            success   = 1'b0;
            m_attempt = 0;
         end
         collide(r, s);
         wait_idle();
         check("attempt random", int'(attempt), m_attempt);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
